vga_syncgen: RTL and testbench

- Video timing generator directly upstream of the pattern generator.
- Divides the system clock CLK into a pixel rate, then counts pixels and lines over a full 800x525 frame.
- Drives pixel coordinates, sync pulses, data-enable, the pixel clock PCK, and a start-of-frame strobe.
- The pattern stage colours pixels from HCNT/VCNT and passes HS/VS/DE/PCK through to the VGA outputs.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/pck_div.sv | 38 +++
 rtl/vga_syncgen.sv | 102 ++++++++++
 tb/tb_vga_syncgen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and a small region-decode helper.
package vga_timing_pkg;

   localparam int CNT_W   = 10;
   localparam int FRAME_W = 16;

   localparam int DEF_PCK_DIV  = 5;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam logic DEF_HS_POL = 1'b0;
   localparam logic DEF_VS_POL = 1'b0;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // lo <= v < hi; bounds are one bit wider so a region may end at 1024.
   function automatic logic in_span(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W:0]   lo,
                                    input logic [CNT_W:0]   hi);
      return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
   endfunction

endpackage

// File: rtl/pck_div.sv
// Pixel-rate divider: registered pixel clock plus a one-cycle pixel tick.
// Internally a down-counter; the equivalent up-count phase is
// dcnt = PCK_DIV-1-dcnt_dn, so terminal count 0 is the dcnt wrap cycle and
// pck is high for dcnt >= PCK_DIV/2 (rising edge mid-pixel).
module pck_div #(
   parameter int PCK_DIV = 5
) (
   input  logic clk,
   input  logic rst,
   output logic pck,
   output logic tick
);

   localparam int DW = $clog2(PCK_DIV);
   localparam logic [DW-1:0] TC_LOAD  = DW'(PCK_DIV - 1);
   localparam logic [DW-1:0] HIGH_MAX = DW'(PCK_DIV - 1 - PCK_DIV / 2);

   logic [DW-1:0] dcnt_dn;
   logic [DW-1:0] dcnt_dn_nx;

   // Terminal count marks the pixel tick and reloads the counter.
   always_comb begin
      tick       = (dcnt_dn == '0);
      dcnt_dn_nx = tick ? TC_LOAD : dcnt_dn - DW'(1);
   end

   // pck is registered from the next phase so it never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt_dn <= TC_LOAD;
         pck     <= 1'b0;
      end else begin
         dcnt_dn <= dcnt_dn_nx;
         pck     <= (dcnt_dn_nx <= HIGH_MAX);
      end
   end

endmodule

// File: rtl/vga_syncgen.sv
// VGA raster timing generator: pixel/line counters, syncs, DE, SOF and frame count.
module vga_syncgen
   import vga_timing_pkg::*;
#(
   parameter int   PCK_DIV  = DEF_PCK_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = DEF_HS_POL,
   parameter logic VS_POL   = DEF_VS_POL
) (
   input  logic               CLK,
   input  logic               RST,
   output logic               PCK,
   output logic               PCK_EN,
   output logic [CNT_W-1:0]   HCNT,
   output logic [CNT_W-1:0]   VCNT,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_DE,
   output logic               SOF,
   output logic [FRAME_W-1:0] FRAME_CNT
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   localparam logic [CNT_W:0] H_DE_END = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] HS_BEG   = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_DE_END = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] VS_BEG   = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic             pix_tick;
   logic             frame_wrap;
   logic [CNT_W-1:0] hcnt_nx;
   logic [CNT_W-1:0] vcnt_nx;

   pck_div #(
      .PCK_DIV (PCK_DIV)
   ) u_pck_div (
      .clk  (CLK),
      .rst  (RST),
      .pck  (PCK),
      .tick (pix_tick)
   );

   // Raster advance: one pixel per tick, with line and frame wrap.
   always_comb begin
      hcnt_nx    = HCNT;
      vcnt_nx    = VCNT;
      frame_wrap = 1'b0;
      if (pix_tick) begin
         if (HCNT == H_LAST) begin
            hcnt_nx = '0;
            if (VCNT == V_LAST) begin
               vcnt_nx    = '0;
               frame_wrap = 1'b1;
            end else begin
               vcnt_nx = VCNT + CNT_W'(1);
            end
         end else begin
            hcnt_nx = HCNT + CNT_W'(1);
         end
      end
   end

   // Everything registers from the next counter values so syncs never skew against HCNT/VCNT.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         HCNT      <= '0;
         VCNT      <= '0;
         VGA_DE    <= 1'b0;
         VGA_HS    <= ~HS_POL;
         VGA_VS    <= ~VS_POL;
         PCK_EN    <= 1'b0;
         SOF       <= 1'b0;
         FRAME_CNT <= '0;
      end else begin
         HCNT   <= hcnt_nx;
         VCNT   <= vcnt_nx;
         VGA_DE <= in_span(hcnt_nx, '0, H_DE_END) && in_span(vcnt_nx, '0, V_DE_END);
         VGA_HS <= in_span(hcnt_nx, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
         VGA_VS <= in_span(vcnt_nx, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
         PCK_EN <= pix_tick;
         SOF    <= frame_wrap;
         if (frame_wrap) begin
            FRAME_CNT <= FRAME_CNT + FRAME_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_syncgen.sv
// Scoreboard bench for vga_syncgen: three instances (small frame at /5, small
// frame at /2 with inverted HS, full 640x480 defaults) against a closed-form model.
module tb_vga_syncgen;

   typedef struct packed {
      logic        pck;
      logic        pck_en;
      logic        hs;
      logic        vs;
      logic        de;
      logic        sof;
      logic [9:0]  h;
      logic [9:0]  v;
      logic [15:0] fr;
   } obs_t;

   typedef struct {
      longint div, ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hpol, vpol;
   } cfg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        pck_w [3];
   logic        en_w  [3];
   logic        hs_w  [3];
   logic        vs_w  [3];
   logic        de_w  [3];
   logic        sof_w [3];
   logic [9:0]  h_w   [3];
   logic [9:0]  v_w   [3];
   logic [15:0] fr_w  [3];

   obs_t   exp_q [3][$];
   longint n_cyc  = 0;
   int     n_chk  = 0;
   int     n_pass = 0;

   always #5 clk = ~clk;

   vga_syncgen #(
      .PCK_DIV(5), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_a (
      .CLK(clk), .RST(rst), .PCK(pck_w[0]), .PCK_EN(en_w[0]), .HCNT(h_w[0]), .VCNT(v_w[0]),
      .VGA_HS(hs_w[0]), .VGA_VS(vs_w[0]), .VGA_DE(de_w[0]), .SOF(sof_w[0]), .FRAME_CNT(fr_w[0])
   );

   vga_syncgen #(
      .PCK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
   ) dut_b (
      .CLK(clk), .RST(rst), .PCK(pck_w[1]), .PCK_EN(en_w[1]), .HCNT(h_w[1]), .VCNT(v_w[1]),
      .VGA_HS(hs_w[1]), .VGA_VS(vs_w[1]), .VGA_DE(de_w[1]), .SOF(sof_w[1]), .FRAME_CNT(fr_w[1])
   );

   vga_syncgen dut_c (
      .CLK(clk), .RST(rst), .PCK(pck_w[2]), .PCK_EN(en_w[2]), .HCNT(h_w[2]), .VCNT(v_w[2]),
      .VGA_HS(hs_w[2]), .VGA_VS(vs_w[2]), .VGA_DE(de_w[2]), .SOF(sof_w[2]), .FRAME_CNT(fr_w[2])
   );

   function automatic cfg_t get_cfg(int id);
      cfg_t c;
      case (id)
         0:       c = '{5, 16, 2, 3, 2, 5, 1, 2, 2, 0, 0};
         1:       c = '{2, 8, 1, 2, 1, 4, 1, 1, 1, 1, 0};
         default: c = '{5, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      endcase
      return c;
   endfunction

   // Expected outputs after n clock edges since reset release (n == 0: reset state).
   function automatic obs_t model(int id, longint n);
      cfg_t   c;
      obs_t   e;
      longint ht, vt, ft, p, ph, h, v;
      c  = get_cfg(id);
      ht = c.ha + c.hfp + c.hsy + c.hbp;
      vt = c.va + c.vfp + c.vsy + c.vbp;
      ft = ht * vt;
      e    = '0;
      e.hs = (c.hpol == 0);
      e.vs = (c.vpol == 0);
      if (n == 0) return e;
      p  = n / c.div;
      ph = n % c.div;
      h  = p % ht;
      v  = (p / ht) % vt;
      e.pck    = (ph >= c.div / 2);
      e.pck_en = (ph == 0);
      e.sof    = (ph == 0) && (p % ft == 0);
      e.h      = 10'(h);
      e.v      = 10'(v);
      e.fr     = 16'((p / ft) % 65536);
      e.de     = (h < c.ha) && (v < c.va);
      if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsy) e.hs = (c.hpol != 0);
      if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsy) e.vs = (c.vpol != 0);
      return e;
   endfunction

   function automatic obs_t get_act(int id);
      return {pck_w[id], en_w[id], hs_w[id], vs_w[id], de_w[id], sof_w[id], h_w[id], v_w[id], fr_w[id]};
   endfunction

   // Model side: track edges since release; an async reset seen mid-cycle clears the count.
   always @(posedge clk) begin
      if (rst) n_cyc = 0;
      else     n_cyc = n_cyc + 1;
      #2;
      if (rst) n_cyc = 0;
      for (int id = 0; id < 3; id++) exp_q[id].push_back(model(id, n_cyc));
   end

   // Monitor side: every cycle each instance presents a full output set; compare on the falling edge.
   always @(negedge clk) begin
      for (int id = 0; id < 3; id++) begin
         if (exp_q[id].size() > 0) begin
            obs_t e;
            obs_t g;
            e = exp_q[id].pop_front();
            g = get_act(id);
            n_chk++;
            if (g === e) begin
               n_pass++;
            end else begin
               $display("FAIL outputs dut%0d @%0t: got pck=%b en=%b hs=%b vs=%b de=%b sof=%b h=%0d v=%0d fr=%0d, required pck=%b en=%b hs=%b vs=%b de=%b sof=%b h=%0d v=%0d fr=%0d",
                        id, $time, g.pck, g.pck_en, g.hs, g.vs, g.de, g.sof, g.h, g.v, g.fr,
                        e.pck, e.pck_en, e.hs, e.vs, e.de, e.sof, e.h, e.v, e.fr);
            end
         end
      end
   end

   task automatic run(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      found = 1'b0;
      rst   = 1'b1;
      run(3);
      rst = 1'b0;
      run(15000);

      // Reset dut_a while it sits inside its vertical sync.
      for (int i = 0; i < 5000; i++) begin
         run(1);
         if (v_w[0] == 10'd6 && h_w[0] >= 10'd10) begin
            found = 1'b1;
            break;
         end
      end
      n_chk++;
      if (found && vs_w[0] === 1'b0) n_pass++;
      else $display("FAIL vs_window dut0: found=%0d vs=%b, required found=1 vs=0", found, vs_w[0]);
      rst = 1'b1;
      #1;
      n_chk++;
      if (vs_w[0] === 1'b1 && h_w[0] === 10'd0 && v_w[0] === 10'd0 && fr_w[0] === 16'd0 && sof_w[0] === 1'b0)
         n_pass++;
      else
         $display("FAIL rst_same_cycle dut0: vs=%b h=%0d v=%0d fr=%0d sof=%b, required vs=1 h=0 v=0 fr=0 sof=0",
                  vs_w[0], h_w[0], v_w[0], fr_w[0], sof_w[0]);
      run(2);
      rst = 1'b0;

      for (int k = 0; k < 20; k++) begin
         run(int'($urandom_range(2000, 50)));
         rst = 1'b1;
         run(int'($urandom_range(4, 1)));
         rst = 1'b0;
      end

      run(12000);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
